// File: rtl/pm_access_ctrl.sv
// Program memory access controller: arbitrates loader writes against fetch reads
// on the shared bidirectional instruction bus and pipelines reads at one per cycle.
module pm_access_ctrl #(
   parameter int unsigned DATA_W = 67,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic [ADDR_W-1:0] pm_addr,
   output logic              pm_rd,
   output logic              pm_wr,
   inout  wire  [DATA_W-1:0] pm_inst
);

   logic              iss_q, iss_d;
   logic              dat_q, dat_d;
   logic              last_wr_q, last_wr_d;
   logic              pm_rd_q, pm_rd_d;
   logic              pm_wr_q, pm_wr_d;
   logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_data_valid_q, rd_data_valid_d;
   logic              wr_acc, rd_acc;

   // Controller owns the bus only during a write cycle; memory may drive otherwise.
   assign pm_inst = pm_wr_q ? wr_data_q : {DATA_W{1'bz}};

   // Arbitration: alternate under contention, drain the read pipe before a write.
   always_comb begin
      wr_ready = !iss_q && !(rd_valid && last_wr_q);
      rd_ready = !(wr_valid && (iss_q || !last_wr_q));
      wr_acc   = wr_valid && wr_ready;
      rd_acc   = rd_valid && rd_ready;
   end

   always_comb begin
      iss_d           = 1'b0;
      last_wr_d       = last_wr_q;
      pm_rd_d         = iss_q;
      pm_wr_d         = 1'b0;
      pm_addr_d       = pm_addr_q;
      wr_data_d       = wr_data_q;
      dat_d           = iss_q;
      rd_data_valid_d = dat_q;
      rd_data_d       = rd_data_q;

      if (wr_acc) begin
         pm_wr_d   = 1'b1;
         pm_rd_d   = 1'b0;
         pm_addr_d = wr_addr;
         wr_data_d = wr_data;
         last_wr_d = 1'b1;
      end else if (rd_acc) begin
         pm_rd_d   = 1'b1;
         pm_addr_d = rd_addr;
         iss_d     = 1'b1;
         last_wr_d = 1'b0;
      end

      // Memory drives the bus throughout the data cycle; sample it here.
      if (dat_q) begin
         rd_data_d = pm_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_q           <= 1'b0;
         dat_q           <= 1'b0;
         last_wr_q       <= 1'b0;
         pm_rd_q         <= 1'b0;
         pm_wr_q         <= 1'b0;
         pm_addr_q       <= '0;
         wr_data_q       <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
      end else begin
         iss_q           <= iss_d;
         dat_q           <= dat_d;
         last_wr_q       <= last_wr_d;
         pm_rd_q         <= pm_rd_d;
         pm_wr_q         <= pm_wr_d;
         pm_addr_q       <= pm_addr_d;
         wr_data_q       <= wr_data_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   assign pm_rd         = pm_rd_q;
   assign pm_wr         = pm_wr_q;
   assign pm_addr       = pm_addr_q;
   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_pm_access_ctrl.sv
// Bench for pm_access_ctrl: program memory model on the shared bus, a grant-history
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_pm_access_ctrl;
   localparam int unsigned DATA_W = 67;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_valid, rd_valid;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready, rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic [ADDR_W-1:0] pm_addr;
   logic              pm_rd, pm_wr;
   wire  [DATA_W-1:0] pm_inst;

   int npass = 0;
   int ntot  = 0;

   pm_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_wr(pm_wr), .pm_inst(pm_inst)
   );

   always #5 clk = ~clk;

   // Program memory: latches on a read strobe, drives the bus while pm_rd is high.
   logic [DATA_W-1:0] ram [32];
   logic [DATA_W-1:0] mem_out;
   always @(posedge clk) begin
      if (pm_wr) ram[pm_addr] <= pm_inst;
      if (pm_rd) mem_out <= ram[pm_addr];
   end
   assign pm_inst = (pm_rd && !pm_wr) ? mem_out : {DATA_W{1'bz}};

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      else npass++;
   endtask

   // Reference model: what was granted at each of the last edges, plus a shadow memory.
   typedef enum logic [1:0] {G_NONE, G_RD, G_WR} grant_e;
   grant_e            h1, h2;
   logic              m_last_wr, m_rdv;
   logic [DATA_W-1:0] d1, d2, m_rd_data, m_wdata;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] mm [32];
   logic              e_wr_ready, e_rd_ready;

   always_comb begin
      e_wr_ready = (h1 != G_RD) && !(rd_valid && m_last_wr);
      e_rd_ready = !(wr_valid && ((h1 == G_RD) || !m_last_wr));
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h1 <= G_NONE; h2 <= G_NONE; m_last_wr <= 1'b0; m_rdv <= 1'b0;
         d1 <= '0; d2 <= '0; m_rd_data <= '0; m_wdata <= '0; m_addr <= '0;
      end else begin
         h2    <= h1;
         d2    <= d1;
         m_rdv <= (h2 == G_RD);
         if (h2 == G_RD) m_rd_data <= d2;
         if (wr_valid && e_wr_ready) begin
            h1 <= G_WR; m_last_wr <= 1'b1; m_addr <= wr_addr;
            m_wdata <= wr_data; mm[wr_addr] <= wr_data;
         end else if (rd_valid && e_rd_ready) begin
            h1 <= G_RD; m_last_wr <= 1'b0; m_addr <= rd_addr; d1 <= mm[rd_addr];
         end else begin
            h1 <= G_NONE;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   logic [DATA_W-1:0] cap [$];
   always @(negedge clk) begin
      chk("wr_ready", wr_ready, e_wr_ready);
      chk("rd_ready", rd_ready, e_rd_ready);
      chk("pm_wr", pm_wr, h1 == G_WR);
      chk("pm_rd", pm_rd, (h1 == G_RD) || (h2 == G_RD && h1 == G_NONE));
      chk("pm_addr", pm_addr, m_addr);
      chk("rd_data_valid", rd_data_valid, m_rdv);
      chk("rd_data", rd_data, m_rd_data);
      chk("no_contention", pm_rd && pm_wr, 1'b0);
      if (pm_wr) chk("bus_wdata", pm_inst, m_wdata);
      if (rd_data_valid) cap.push_back(rd_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      chk("rst_pm_rd", pm_rd, 1'b0);
      chk("rst_pm_wr", pm_wr, 1'b0);
      chk("rst_pm_addr", pm_addr, '0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_rd_data_valid", rd_data_valid, 1'b0);

      // Single write then read-back of the same address.
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 67'h5_DEAD_BEEF;
      cyc();
      wr_valid = 1'b0;
      chk("t1_wr_strobe", pm_wr, 1'b1);
      rd_valid = 1'b1; rd_addr = 5'd3;
      cyc();
      rd_valid = 1'b0;
      chk("t1_wr_one_cycle", pm_wr, 1'b0);
      chk("t1_issue", pm_rd, 1'b1);
      cyc();
      chk("t1_not_yet", rd_data_valid, 1'b0);
      cyc();
      chk("t1_valid", rd_data_valid, 1'b1);
      chk("t1_data", rd_data, 67'h5_DEAD_BEEF);
      cyc();
      chk("t1_pulse", rd_data_valid, 1'b0);

      // Preload 0..3 then back-to-back reads.
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(10 + i);
         cyc();
      end
      wr_valid = 1'b0;
      cap.delete();
      for (int i = 0; i < 4; i++) begin
         rd_valid = 1'b1; rd_addr = ADDR_W'(i);
         cyc();
      end
      rd_valid = 1'b0;
      repeat (4) cyc();
      chk("t2_count", DATA_W'(cap.size()), 67'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < cap.size()) chk("t2_data", cap[i], DATA_W'(10 + i));
      end

      // Both requesters held from reset: W, R, bubble, W, ...
      rst_n = 1'b0;
      wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 5'd5; wr_data = 67'h1234; rd_addr = 5'd0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      cyc();
      chk("t3_w0", pm_wr, 1'b1);
      chk("t3_w0_rd", pm_rd, 1'b0);
      wr_addr = 5'd6; wr_data = 67'h5678;
      cyc();
      chk("t3_r1", pm_rd, 1'b1);
      chk("t3_r1_wr", pm_wr, 1'b0);
      cyc();
      chk("t3_bubble_rd", pm_rd, 1'b1);
      chk("t3_bubble_wr", pm_wr, 1'b0);
      cyc();
      chk("t3_w3", pm_wr, 1'b1);
      repeat (4) cyc();
      wr_valid = 1'b0; rd_valid = 1'b0;
      repeat (3) cyc();

      // Write arrives during a read stream.
      for (int i = 0; i < 3; i++) begin
         rd_valid = 1'b1; rd_addr = ADDR_W'(i);
         cyc();
      end
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 67'h7_0000_0007; rd_addr = 5'd3;
      #1;
      chk("t4_rd_blocked", rd_ready, 1'b0);
      chk("t4_wr_blocked", wr_ready, 1'b0);
      cyc();
      chk("t4_data_cycle_rd", pm_rd, 1'b1);
      chk("t4_data_cycle_wr", pm_wr, 1'b0);
      cyc();
      wr_valid = 1'b0;
      chk("t4_write", pm_wr, 1'b1);
      chk("t4_write_rd", pm_rd, 1'b0);
      repeat (5) cyc();
      rd_valid = 1'b0;
      repeat (4) cyc();

      // Reset asserted during a data cycle.
      rd_valid = 1'b1; rd_addr = 5'd1;
      cyc();
      rd_valid = 1'b0;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_pm_rd", pm_rd, 1'b0);
      chk("t5_pm_wr", pm_wr, 1'b0);
      chk("t5_pm_addr", pm_addr, '0);
      chk("t5_rd_data", rd_data, '0);
      chk("t5_rd_data_valid", rd_data_valid, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      cap.delete();
      repeat (5) cyc();
      chk("t5_no_late_valid", DATA_W'(cap.size()), 67'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
